// File: rtl/sys_reg_file.sv
// -----------------------------------------------------------------------------
// sys_reg_file
//
// Configuration and operand register file for the reference clock domain. It
// sits directly downstream of the system controller. It holds 16 x 8-bit
// flip-flop entries that the controller accesses over one single-port
// Address/WrEn/RdEn/WrData bus. Read data comes back registered, together with
// a one-cycle valid strobe. Entries 0-3 are also exported continuously so
// other blocks can use them.
//
// Ports
//   CLK           reference clock, all state updates on the rising edge
//   RST           asynchronous, active-low reset
//   Address       entry index for a write or a read
//   WrEn          write request
//   RdEn          read request
//   WrData        write data
//   RdData        registered read data (holds between reads)
//   RdData_Valid  one-cycle strobe per accepted read
//   REG0          entry 0 (ALU operand A)
//   REG1          entry 1 (ALU operand B)
//   REG2          entry 2: [0] parity enable, [1] parity type (1 = odd),
//                 [7:2] UART prescale
//   REG3          entry 3 (clock-divider ratio)
// -----------------------------------------------------------------------------
module sys_reg_file #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic                  WrEn,
    input  logic                  RdEn,
    input  logic [DATA_WIDTH-1:0] WrData,
    output logic [DATA_WIDTH-1:0] RdData,
    output logic                  RdData_Valid,
    output logic [DATA_WIDTH-1:0] REG0,
    output logic [DATA_WIDTH-1:0] REG1,
    output logic [DATA_WIDTH-1:0] REG2,
    output logic [DATA_WIDTH-1:0] REG3
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [DATA_WIDTH-1:0] rd_data_d;
    logic                  rd_valid_q;
    logic                  rd_valid_d;

    // Power-on contents. Entry 2 enables even parity with prescale 32.
    // Entry 3 selects a divide ratio of 32. Every other entry is cleared.
    function automatic logic [DATA_WIDTH-1:0] reset_value(input int idx);
        case (idx)
            32'sd2:  reset_value = DATA_WIDTH'(8'h81);
            32'sd3:  reset_value = DATA_WIDTH'(8'h20);
            default: reset_value = '0;
        endcase
    endfunction

    // Next-state decode. When a write and a read are requested together, the
    // whole request is dropped, so neither side effect happens.
    always_comb begin
        regs_d     = regs_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        if (WrEn && !RdEn) begin
            regs_d[Address] = WrData;
        end else if (RdEn && !WrEn) begin
            rd_data_d  = regs_q[Address];
            rd_valid_d = 1'b1;
        end else begin
            rd_valid_d = 1'b0;
        end
    end

    // Storage and read-port registers. Reset is asynchronous, so a reset in
    // the middle of a read drops the valid strobe at once.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= reset_value(i);
            end
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign RdData       = rd_data_q;
    assign RdData_Valid = rd_valid_q;
    assign REG0         = regs_q[0];
    assign REG1         = regs_q[1];
    assign REG2         = regs_q[2];
    assign REG3         = regs_q[3];

endmodule

// File: tb/tb_sys_reg_file.sv
// -----------------------------------------------------------------------------
// tb_sys_reg_file
//
// Scoreboard bench for sys_reg_file. The driver issues directed operations
// and then randomized ones. A plain array holds the register-file contents.
// Each accepted read pushes its expected data and its due cycle into a queue.
// An independent monitor runs on the falling edge. Each time the DUT presents
// RdData_Valid, the monitor pops that queue. It also checks that RdData holds
// between reads and that REG0-REG3 track the model.
// -----------------------------------------------------------------------------
module tb_sys_reg_file;

    logic       CLK;
    logic       RST;
    logic [3:0] Address;
    logic       WrEn;
    logic       RdEn;
    logic [7:0] WrData;
    logic [7:0] RdData;
    logic       RdData_Valid;
    logic [7:0] REG0;
    logic [7:0] REG1;
    logic [7:0] REG2;
    logic [7:0] REG3;

    sys_reg_file #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .Address      (Address),
        .WrEn         (WrEn),
        .RdEn         (RdEn),
        .WrData       (WrData),
        .RdData       (RdData),
        .RdData_Valid (RdData_Valid),
        .REG0         (REG0),
        .REG1         (REG1),
        .REG2         (REG2),
        .REG3         (REG3)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] data;
        int         due;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] mem [16];
    int         cyc;
    int         errors;
    int         checks;
    logic [7:0] last_rd;
    bit         done;

    // Rising-edge counter, used to time-stamp when each read result is due.
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%02h expected 0x%02h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // The register file as it is after reset.
    task automatic model_reset();
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        mem[2] = 8'h81;
        mem[3] = 8'h20;
    endtask

    // One bus cycle. Inputs are driven 1 time unit after the rising edge.
    // A read pushes the value the model holds now. A write updates the model
    // after the edge that commits it.
    task automatic op(input bit we, input bit re, input logic [3:0] a, input logic [7:0] d);
        exp_t e;
        WrEn    = we;
        RdEn    = re;
        Address = a;
        WrData  = d;
        if (re && !we) begin
            e.data = mem[a];
            e.due  = cyc + 1;
            exp_q.push_back(e);
        end
        @(posedge CLK);
        #1;
        if (we && !re) mem[a] = d;
    endtask

    // Monitor: scoreboard pop and compare, plus reset-response checks.
    always @(negedge CLK or negedge RST) begin
        if (!RST) begin
            #1;
            chk("reset_valid_low", {7'd0, RdData_Valid}, 8'h00);
            chk("reset_rddata", RdData, 8'h00);
            chk("reset_reg2", REG2, 8'h81);
            chk("reset_reg3", REG3, 8'h20);
            exp_q.delete();
            last_rd = 8'h00;
        end else if (done) begin
            chk("queue_drained", 8'(exp_q.size()), 8'h00);
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end else begin
            chk("reg0", REG0, mem[0]);
            chk("reg1", REG1, mem[1]);
            chk("reg2", REG2, mem[2]);
            chk("reg3", REG3, mem[3]);
            if (RdData_Valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_valid", 8'h01, 8'h00);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("read_latency", 8'(cyc - e.due), 8'h00);
                    chk("read_data", RdData, e.data);
                    last_rd = e.data;
                end
            end else begin
                chk("rddata_hold", RdData, last_rd);
                if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
                    chk("missing_valid", 8'h00, 8'h01);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // Driver: directed scenarios first, then randomized traffic.
    initial begin
        errors  = 0;
        checks  = 0;
        cyc     = 0;
        done    = 1'b0;
        last_rd = 8'h00;
        RST     = 1'b0;
        WrEn    = 1'b0;
        RdEn    = 1'b0;
        Address = 4'h0;
        WrData  = 8'h00;
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b1;

        // Reset defaults, reading every address with an idle cycle between.
        for (int i = 0; i < 16; i++) begin
            op(1'b0, 1'b1, 4'(i), 8'h00);
            op(1'b0, 1'b0, 4'h0, 8'h00);
        end

        // Write 0xA0+i everywhere, then read them all back to back.
        for (int i = 0; i < 16; i++) op(1'b1, 1'b0, 4'(i), 8'hA0 + 8'(i));
        for (int i = 0; i < 16; i++) op(1'b0, 1'b1, 4'(i), 8'h00);
        op(1'b0, 1'b0, 4'h0, 8'h00);

        // Read straight after a write to the same address.
        op(1'b1, 1'b0, 4'd7, 8'h5C);
        op(1'b0, 1'b1, 4'd7, 8'h00);
        op(1'b0, 1'b0, 4'h0, 8'h00);

        // Write and read requested together: nothing happens.
        op(1'b1, 1'b0, 4'd4, 8'h11);
        op(1'b1, 1'b1, 4'd4, 8'hFF);
        op(1'b0, 1'b0, 4'h0, 8'h00);
        op(1'b0, 1'b1, 4'd4, 8'h00);
        op(1'b0, 1'b0, 4'h0, 8'h00);

        // Sustained read while the address steps 0, 1, 2.
        op(1'b1, 1'b0, 4'd0, 8'h10);
        op(1'b1, 1'b0, 4'd1, 8'h20);
        op(1'b1, 1'b0, 4'd2, 8'h30);
        op(1'b0, 1'b1, 4'd0, 8'h00);
        op(1'b0, 1'b1, 4'd1, 8'h00);
        op(1'b0, 1'b1, 4'd2, 8'h00);
        op(1'b0, 1'b0, 4'h0, 8'h00);

        // Randomized traffic, conflicts included.
        for (int n = 0; n < 400; n++) begin
            op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
        end
        op(1'b0, 1'b0, 4'h0, 8'h00);

        // Reset while a read result is valid.
        op(1'b1, 1'b0, 4'd3, 8'h77);
        op(1'b0, 1'b1, 4'd3, 8'h00);
        RdEn = 1'b0;
        #1;
        RST = 1'b0;
        model_reset();
        @(posedge CLK);
        #1;
        RST = 1'b1;
        for (int i = 0; i < 5; i++) op(1'b0, 1'b1, 4'(i), 8'h00);
        op(1'b0, 1'b0, 4'h0, 8'h00);
        op(1'b0, 1'b0, 4'h0, 8'h00);

        done = 1'b1;
        repeat (5) @(posedge CLK);
        $display("FAIL monitor_timeout: summary not reached");
        $fatal(1, "monitor did not finish");
    end

endmodule
